// File: rtl/bist_fail_logger_if.sv
// ---------------------------------------------------------------------------
// bist_fail_logger_if
// Read port between the BIST fail logger and the external tester.
// A valid/ready handshake carrying one logged fail per transfer.
//
// Signals:
//   rd_valid    - head log entry available (logger -> tester)
//   rd_ready    - tester accepts the head entry (tester -> logger)
//   rd_addr     - RAM address of the head entry
//   rd_syndrome - expected ^ actual bit syndrome of the head entry
//
// Modports:
//   master - logger side (drives valid/addr/syndrome, samples ready)
//   slave  - tester side (drives ready, samples valid/addr/syndrome)
// ---------------------------------------------------------------------------
interface bist_fail_logger_if #(
  parameter int SIZE   = 6,
  parameter int LENGTH = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [SIZE-1:0]   rd_addr;
  logic [LENGTH-1:0] rd_syndrome;

  modport master (
    output rd_valid,
    output rd_addr,
    output rd_syndrome,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_addr,
    input  rd_syndrome,
    output rd_ready
  );
endinterface

// File: rtl/bist_fail_logger.sv
// ---------------------------------------------------------------------------
// bist_fail_logger
// Capture side of the memory BIST compare path. While the BIST engine runs
// the SRAM in test mode (NbarT=1) each fail strobe records the failing
// address and syndrome (expected ^ actual) into a small FIFO log. After the
// NbarT falling edge the log is presented to a tester over a valid/ready
// read port, with a saturating fail count and a sticky overflow flag.
//
// Optional feature macro: BIST_LOG_DEDUP_EN
//   When defined, a fail whose address matches the most recently pushed
//   address (since the last start) is counted but not pushed.
//
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   start               - clear the log and arm a new session
//   NbarT               - test mode from BIST controller (1 = test)
//   fail_in             - compare fail strobe for this cycle
//   addr_in             - RAM address of the compared read
//   expected, actual    - pattern data and RAM data
//   rd                  - read port (bist_fail_logger_if.master)
//   fail_count          - saturating fail count for this session
//   overflow            - a fail arrived while the log was full (sticky)
//   busy / done         - state is ARMED / DONE
// ---------------------------------------------------------------------------
module bist_fail_logger #(
  parameter int SIZE   = 6,
  parameter int LENGTH = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                NbarT,
  input  logic                fail_in,
  input  logic [SIZE-1:0]     addr_in,
  input  logic [LENGTH-1:0]   expected,
  input  logic [LENGTH-1:0]   actual,
  bist_fail_logger_if.master  rd,
  output logic [CNT_W-1:0]    fail_count,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] FC_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FC_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] FC_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [LENGTH-1:0] calc_syndrome(
    input logic [LENGTH-1:0] exp_v,
    input logic [LENGTH-1:0] act_v
  );
    return exp_v ^ act_v;
  endfunction

  state_t             state_q,      state_d;
  logic [PW-1:0]      wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q,     rd_ptr_d;
  logic [CW-1:0]      count_q,      count_d;
  logic [CNT_W-1:0]   fail_count_q, fail_count_d;
  logic               overflow_q,   overflow_d;
  logic               nbart_q,      nbart_d;
`ifdef BIST_LOG_DEDUP_EN
  logic [SIZE-1:0]    last_addr_q,  last_addr_d;
  logic               last_vld_q,   last_vld_d;
`endif

  logic [SIZE-1:0]    mem_addr_q [DEPTH];
  logic [LENGTH-1:0]  mem_syn_q  [DEPTH];

  logic               push_s;
  logic               pop_s;
  logic               dup_s;
  logic               full_s;
  logic               rd_valid_s;

  // Duplicate detection against the last pushed address (feature-gated).
  always_comb begin
`ifdef BIST_LOG_DEDUP_EN
    dup_s = last_vld_q && (addr_in == last_addr_q);
`else
    dup_s = 1'b0;
`endif
  end

  // Next-state, FIFO bookkeeping and counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    nbart_d      = NbarT;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    full_s       = (count_q == CNT_FULL);
`ifdef BIST_LOG_DEDUP_EN
    last_addr_d  = last_addr_q;
    last_vld_d   = last_vld_q;
`endif
    if (start) begin
      // start overrides everything else in this cycle, including fail_in
      state_d      = ST_ARMED;
      wr_ptr_d     = PTR_ZERO;
      rd_ptr_d     = PTR_ZERO;
      count_d      = CNT_ZERO;
      fail_count_d = FC_ZERO;
      overflow_d   = 1'b0;
`ifdef BIST_LOG_DEDUP_EN
      last_vld_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (fail_in) begin
            if (fail_count_q != FC_MAX) begin
              fail_count_d = fail_count_q + FC_ONE;
            end else begin
              fail_count_d = fail_count_q;
            end
            if (dup_s) begin
              // duplicate address: counted only, never an overflow
              push_s = 1'b0;
            end else if (full_s) begin
              overflow_d = 1'b1;
            end else begin
              push_s   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              count_d  = count_q + CNT_ONE;
`ifdef BIST_LOG_DEDUP_EN
              last_addr_d = addr_in;
              last_vld_d  = 1'b1;
`endif
            end
          end else begin
            push_s = 1'b0;
          end
          // session ends on the NbarT falling edge; this cycle's fail is kept
          if (nbart_q && !NbarT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_DONE: begin
          if (rd_valid_s && rd.rd_ready) begin
            pop_s    = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
          end else begin
            pop_s = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      fail_count_q <= FC_ZERO;
      overflow_q   <= 1'b0;
      nbart_q      <= 1'b0;
`ifdef BIST_LOG_DEDUP_EN
      last_addr_q  <= {SIZE{1'b0}};
      last_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
      nbart_q      <= nbart_d;
`ifdef BIST_LOG_DEDUP_EN
      last_addr_q  <= last_addr_d;
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  // Log storage; contents are only visible through count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_q[wr_ptr_q] <= addr_in;
      mem_syn_q[wr_ptr_q]  <= calc_syndrome(expected, actual);
    end
  end

  // Read port: head entry only in DONE with a non-empty log, zero otherwise.
  always_comb begin
    rd_valid_s = (state_q == ST_DONE) && (count_q != CNT_ZERO);
    if (rd_valid_s) begin
      rd.rd_addr     = mem_addr_q[rd_ptr_q];
      rd.rd_syndrome = mem_syn_q[rd_ptr_q];
    end else begin
      rd.rd_addr     = {SIZE{1'b0}};
      rd.rd_syndrome = {LENGTH{1'b0}};
    end
  end

  assign rd.rd_valid  = rd_valid_s;
  assign fail_count   = fail_count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q == ST_ARMED);
  assign done         = (state_q == ST_DONE);

endmodule

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
Capture side of the memory BIST compare path. While the BIST engine drives the SRAM in test mode (NbarT=1), this block samples each per-cycle fail strobe and records the failing address and bit syndrome (expected XOR actual) into a small FIFO log. After the test it presents the log to an external tester over a valid/ready read port, together with a saturating fail count and an overflow flag.

Parameters:
SIZE, 6, RAM address width
LENGTH, 8, RAM data width
DEPTH, 4, log entries (power of two, >=2)
CNT_W, 8, fail counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  clear log and arm a new session
NbarT  input  1  test mode from BIST controller (1 = test)
fail_in  input  1  compare fail strobe for this cycle
addr_in  input  SIZE  RAM address of the compared read
expected  input  LENGTH  pattern data expected
actual  input  LENGTH  RAM data returned
rd_ready  input  1  tester accepts head entry
rd_valid  output  1  head entry available
rd_addr  output  SIZE  head entry address
rd_syndrome  output  LENGTH  head entry expected^actual
fail_count  output  CNT_W  total fails this session, saturating
overflow  output  1  a fail arrived while log full (sticky)
busy  output  1  state == ARMED
done  output  1  state == DONE

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO pointers, entry count, fail_count, overflow, NbarT_q cleared; every output 0. Reset mid-session discards all entries.
- States IDLE, ARMED, DONE. NbarT_q = NbarT registered each cycle.
- start=1 in any state: next state ARMED; FIFO emptied; fail_count=0; overflow=0. start has priority over fail_in, pop and the NbarT edge in the same cycle (that cycle's fail is not logged or counted).
- ARMED: on fail_in=1 -> fail_count+1, saturating at 2^CNT_W-1. If FIFO not full, push {addr_in, expected^actual}; if full, drop the entry and set overflow=1.
- ARMED -> DONE when NbarT_q=1 and NbarT=0 (falling edge). A fail in the edge cycle is still logged. Arming with NbarT=0 waits in ARMED until NbarT has risen and fallen.
- DONE: fail_in ignored. rd_valid = !empty (combinational from state and count); rd_addr/rd_syndrome = head entry, 0 when empty. Pop on rd_valid && rd_ready; next entry visible the following cycle. rd_ready while empty has no effect. DONE holds until start or rst.
- IDLE and ARMED: rd_valid=0; rd_addr=0; rd_syndrome=0; rd_ready ignored.
- Push and pop never occur in the same cycle (different states).
- FIFO pointers wrap modulo DEPTH. A separate entry count of width log2(DEPTH)+1 distinguishes full from empty.
- Latency: fail at edge N is readable (in DONE) at the earliest after the NbarT falling edge. fail_count updates at edge N.

Optional Feature:
BIST_LOG_DEDUP_EN
- Defined: a fail whose addr_in equals the most recently pushed address (valid since last start) is not pushed. fail_count still increments. A dropped duplicate never sets overflow. The last-address register is cleared by start/rst.
- Undefined: every fail is pushed subject to the full rule.

Test Plan:
1. Single fail: start; NbarT=1; fail_in at addr 0x15, expected 0xAA, actual 0xA8; NbarT=0 -> done=1, rd_valid=1, rd_addr=0x15, rd_syndrome=0x02, fail_count=1, overflow=0.
2. Overflow: 6 fails at addrs 0..5, then NbarT falls -> entries read in order 0,1,2,3 with pops; rd_valid=0 after the 4th pop; fail_count=6; overflow=1.
3. Backpressure: 2 entries logged, rd_ready=0 for 5 cycles -> rd_addr stable at the first address. rd_ready=1 for 2 cycles -> both popped, rd_valid=0; further rd_ready has no effect.
4. Start priority and restart: in DONE with 3 entries, start=1 with fail_in=1 -> next cycle busy=1, fail_count=0, overflow=0, FIFO empty.
5. Reset mid-log: ARMED with 2 entries and fail_count=2, assert rst asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; fail_in ignored until start.
6. Dedup (BIST_LOG_DEDUP_EN): fails at addr 0x07, 0x07, 0x08, 0x07 -> entries 0x07, 0x08, 0x07; fail_count=4. Without the macro: 4 entries.
